pkt_rd_engine: RTL

PKT_RD_ENGINE -- requirements
Module: pkt_rd_engine

---
 rtl/pkt_pkg.sv | 25 ++
 rtl/pkt_rd_engine.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pkt_pkg.sv
//==============================================================================
// Module  : pkt_pkg
// Purpose : Shared widths and the read-engine state encoding for the packet
//           path. Imported by pkt_rd_engine and its bench.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package pkt_pkg;

  localparam int DATA_W  = 32;  // sink / buffer word width
  localparam int LEN_W   = 16;  // byte-length and word-counter width
  localparam int EMPTY_W = 2;   // invalid-byte count on the eop beat

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_SOP = 3'd1,
    ST_XFER     = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/pkt_rd_engine.sv
//==============================================================================
// Module  : pkt_rd_engine
// Purpose : On a start command, waits for a start-of-packet beat on the sink,
//           copies the packet into a buffer with zero-latency writes, truncates
//           it at MAX_WORDS (draining the rest), records the byte length and
//           pulses rdy once the packet has been fully consumed.
// Ports   : clk, reset (synchronous, active-low)
//           start  in   command pulse, honoured only in IDLE
//           rdy    out  one-cycle completion pulse
//           busy   out  FSM not in IDLE
//           snk_*       valid/ready streaming sink with sop/eop/empty
//           buf_*       buffer write strobe, data, and back-pressure (full)
//           pkt_len out byte length of the last packet
//           trunc   out last packet exceeded MAX_WORDS
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module pkt_rd_engine
  import pkt_pkg::*;
#(
  parameter int MAX_WORDS = 384
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               rdy,
  output logic               busy,
  input  logic               snk_valid,
  output logic               snk_ready,
  input  logic               snk_sop,
  input  logic               snk_eop,
  input  logic [DATA_W-1:0]  snk_data,
  input  logic [EMPTY_W-1:0] snk_empty,
  output logic               buf_wr,
  output logic [DATA_W-1:0]  buf_data,
  input  logic               buf_full,
  output logic [LEN_W-1:0]   pkt_len,
  output logic               trunc
);

  localparam logic [LEN_W-1:0] MAX_CNT   = LEN_W'(MAX_WORDS);
  localparam logic [LEN_W-1:0] MAX_BYTES = LEN_W'(MAX_WORDS * 4);

  rd_state_e        state;
  rd_state_e        state_nxt;
  logic [LEN_W-1:0] word_cnt;
  logic [LEN_W-1:0] cnt_base;
  logic [LEN_W-1:0] words_after;
  logic [LEN_W-1:0] len_eop;
  logic             accept;
  logic             hits_max;
  logic             in_write_state;

  // The sop beat in WAIT_SOP starts a fresh count, so the counter value left
  // over from the previous packet is ignored there rather than cleared first.
  assign cnt_base    = (state == ST_WAIT_SOP) ? '0 : word_cnt;
  assign words_after = cnt_base + LEN_W'(1);
  assign hits_max    = (words_after == MAX_CNT);
  assign len_eop     = {words_after[LEN_W-3:0], 2'b00} - LEN_W'(snk_empty);

  assign accept = snk_valid && snk_ready;

  assign in_write_state = ((state == ST_WAIT_SOP) && snk_sop) || (state == ST_XFER);

  // Write strobe is built straight from the handshake terms so the buffer
  // sees the beat in the same cycle it is accepted.
  assign buf_wr   = reset && snk_valid && !buf_full && in_write_state;
  assign buf_data = snk_data;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_WAIT_SOP;
      end
      ST_WAIT_SOP: begin
        if (accept && snk_sop) begin
          if (snk_eop)       state_nxt = ST_DONE;
          else if (hits_max) state_nxt = ST_DRAIN;
          else               state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        if (accept) begin
          if (snk_eop)       state_nxt = ST_DONE;
          else if (hits_max) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (accept && snk_eop) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output logic; everything is held low while reset is asserted so the
  // outputs are quiet even before the state register has been cleared.
  always_comb begin
    snk_ready = 1'b0;
    rdy       = 1'b0;
    busy      = 1'b0;
    if (reset) begin
      busy = (state != ST_IDLE);
      case (state)
        ST_WAIT_SOP, ST_XFER: snk_ready = !buf_full;
        ST_DRAIN:             snk_ready = 1'b1;
        ST_DONE:              rdy       = 1'b1;
        default:              snk_ready = 1'b0;
      endcase
    end
  end

  // Word counter, truncation flag and length register
  always_ff @(posedge clk) begin
    if (!reset) begin
      word_cnt <= '0;
      pkt_len  <= '0;
      trunc    <= 1'b0;
    end else if (buf_wr) begin
      word_cnt <= words_after;
      if (state == ST_WAIT_SOP) trunc <= 1'b0;
      if (snk_eop) begin
        pkt_len <= len_eop;
      end else if (hits_max) begin
        trunc <= 1'b1;
      end
    end else if ((state == ST_DRAIN) && accept && snk_eop) begin
      pkt_len <= MAX_BYTES;
    end
  end

endmodule

`default_nettype wire
